// File: rtl/clkdiv_cfg_arbiter.sv
// Round-robin arbiter that owns the clock_divider config inputs and holds off changes until settled.
// Optional macro CLKDIV_ARB_SKIP_SAME_EN: identical accepted requests skip delay_valid and SETTLE.
module clkdiv_cfg_arbiter #(
   parameter int         NREQ      = 4,
   parameter logic [6:0] RST_RATIO = 7'd2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [7*NREQ-1:0]   req_ratio,
   input  logic [7*NREQ-1:0]   req_delay,
   output logic [NREQ-1:0]     req_ready,
   output logic [NREQ-1:0]     req_err,
   output logic [6:0]          decimation_ratio,
   output logic [6:0]          delay,
   output logic                delay_valid,
   output logic                busy,
   output logic [2:0]          owner
);

   typedef enum logic {IDLE, SETTLE} state_t;

   state_t          state, state_nx;
   logic [8:0]      cnt, cnt_nx;
   logic [2:0]      ptr, ptr_nx, owner_nx;
   logic [NREQ-1:0] rdy_nx, err_nx, elig;
   logic [6:0]      ratio_nx, delay_nx;
   logic            dv_nx, found, skip;
   logic [2:0]      win;
   logic [6:0]      w_ratio, w_delay;
   int              j;

   // A requester sees its ready one cycle late, so mask it out while the pulse is up.
   assign elig = req_valid & ~req_ready;

   always_comb begin
      found = 1'b0;
      win   = 3'd0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!found && elig[j]) begin
            found = 1'b1;
            win   = 3'(j);
         end
      end
   end

   assign w_ratio = req_ratio[int'(win)*7 +: 7];
   assign w_delay = req_delay[int'(win)*7 +: 7];

`ifdef CLKDIV_ARB_SKIP_SAME_EN
   assign skip = (w_ratio == decimation_ratio) && (w_delay == delay);
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ptr_nx   = ptr;
      owner_nx = owner;
      rdy_nx   = '0;
      err_nx   = '0;
      ratio_nx = decimation_ratio;
      delay_nx = delay;
      dv_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               rdy_nx   = NREQ'(1) << win;
               owner_nx = win;
               ptr_nx   = (int'(win) == NREQ-1) ? 3'd0 : win + 3'd1;
               if (w_ratio == 7'd0) begin
                  err_nx = NREQ'(1) << win;
               end else if (!skip) begin
                  ratio_nx = w_ratio;
                  delay_nx = w_delay;
                  dv_nx    = 1'b1;
                  cnt_nx   = {2'b00, w_delay} + {1'b0, w_ratio, 1'b0};
                  state_nx = SETTLE;
               end
            end
         end
         SETTLE: begin
            // Counter was loaded with delay+2*ratio; leave after exactly that many cycles.
            cnt_nx = cnt - 9'd1;
            if (cnt == 9'd1) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= '0;
         ptr              <= '0;
         owner            <= '0;
         req_ready        <= '0;
         req_err          <= '0;
         decimation_ratio <= RST_RATIO;
         delay            <= '0;
         delay_valid      <= 1'b0;
         busy             <= 1'b0;
      end else begin
         state            <= state_nx;
         cnt              <= cnt_nx;
         ptr              <= ptr_nx;
         owner            <= owner_nx;
         req_ready        <= rdy_nx;
         req_err          <= err_nx;
         decimation_ratio <= ratio_nx;
         delay            <= delay_nx;
         delay_valid      <= dv_nx;
         busy             <= (state_nx == SETTLE);
      end
   end

endmodule

// File: tb/tb_clkdiv_cfg_arbiter.sv
// Randomized + directed bench for clkdiv_cfg_arbiter against a cycle-count reference model.
module tb_clkdiv_cfg_arbiter;
   localparam int NREQ = 4;
`ifdef CLKDIV_ARB_SKIP_SAME_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [7*NREQ-1:0]   req_ratio, req_delay;
   logic [NREQ-1:0]     req_ready, req_err;
   logic [6:0]          decimation_ratio, delay;
   logic                delay_valid, busy;
   logic [2:0]          owner;

   clkdiv_cfg_arbiter #(.NREQ(NREQ), .RST_RATIO(7'd2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ratio(req_ratio),
      .req_delay(req_delay), .req_ready(req_ready), .req_err(req_err),
      .decimation_ratio(decimation_ratio), .delay(delay),
      .delay_valid(delay_valid), .busy(busy), .owner(owner));

   always #5 clk = ~clk;

   // requester agents
   logic [NREQ-1:0] a_valid, cool;
   int              a_ratio [NREQ];
   int              a_delay [NREQ];

   always_comb begin
      req_valid = a_valid;
      req_ratio = '0;
      req_delay = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ratio[7*i +: 7] = 7'(a_ratio[i]);
         req_delay[7*i +: 7] = 7'(a_delay[i]);
      end
   end

   // reference model: remaining settle cycles plus current config
   int              m_left, m_ratio, m_delay, m_owner, m_ptr;
   logic [NREQ-1:0] exp_ready, exp_err;
   logic            exp_dv;
   int              errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_left = 0; m_ratio = 2; m_delay = 0; m_owner = 0; m_ptr = 0;
      exp_ready = '0; exp_err = '0; exp_dv = 1'b0;
   endtask

   task automatic model_step();
      int w;
      w = -1;
      exp_ready = '0; exp_err = '0; exp_dv = 1'b0;
      if (m_left > 0) m_left--;
      else begin
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && a_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         if (w >= 0) begin
            exp_ready[w] = 1'b1;
            m_owner = w;
            m_ptr = (w + 1) % NREQ;
            if (a_ratio[w] == 0) exp_err[w] = 1'b1;
            else if (!(SKIP && a_ratio[w] == m_ratio && a_delay[w] == m_delay)) begin
               m_ratio = a_ratio[w];
               m_delay = a_delay[w];
               exp_dv  = 1'b1;
               m_left  = a_delay[w] + 2 * a_ratio[w];
            end
         end
      end
   endtask

   task automatic check_all();
      chk("ready", 32'(req_ready), 32'(exp_ready));
      chk("err", 32'(req_err), 32'(exp_err));
      chk("dv", 32'(delay_valid), 32'(exp_dv));
      chk("ratio", 32'(decimation_ratio), 32'(m_ratio));
      chk("delay", 32'(delay), 32'(m_delay));
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("owner", 32'(owner), 32'(m_owner));
   endtask

   // one clock: model consumes the inputs that the edge will sample, then compare
   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
      for (int i = 0; i < NREQ; i++) begin
         cool[i] = exp_ready[i];
         if (exp_ready[i]) a_valid[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      a_valid = '0; cool = '0;
      rst = 1'b1;
      model_reset();
      #2;
      check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic request(input int i, input int r, input int d);
      a_valid[i] = 1'b1; a_ratio[i] = r; a_delay[i] = d;
   endtask

   int n, order[5], got;
   bit re0;

   initial begin
      for (int i = 0; i < NREQ; i++) begin a_ratio[i] = 0; a_delay[i] = 0; end
      do_reset();
      chk("rst_ratio", 32'(decimation_ratio), 32'd2);
      chk("rst_busy", 32'(busy), 32'd0);

      // single request from 2
      request(2, 5, 3);
      step();
      chk("single_ready", 32'(req_ready), 32'b0100);
      chk("single_cfg", {25'd0, decimation_ratio}, 32'd5);
      chk("single_owner", 32'(owner), 32'd2);
      n = 0;
      for (int c = 0; c < 40 && busy; c++) begin n++; step(); end
      chk("busy_len", n, 32'd13);

      // all four at once, then 0 re-requests
      do_reset();
      for (int i = 0; i < NREQ; i++) request(i, 1, 0);
      got = 0; re0 = 1'b0;
      for (int c = 0; c < 100 && got < 5; c++) begin
         if (re0 && !cool[0] && !a_valid[0] && got == 1) request(0, 1, 0);
         step();
         for (int i = 0; i < NREQ; i++)
            if (req_ready[i] && got < 5) begin order[got] = i; got++; end
         if (got == 1) re0 = 1'b1;
      end
      chk("grant_cnt", got, 32'd5);
      for (int k = 0; k < 5; k++) chk("order", order[k], (k == 4) ? 0 : k);
      for (int c = 0; c < 10; c++) step();

      // reject ratio 0
      request(1, 0, 9);
      step();
      chk("rej_ready", 32'(req_ready), 32'b0010);
      chk("rej_err", 32'(req_err), 32'b0010);
      chk("rej_busy", 32'(busy), 32'd0);
      chk("rej_ratio", 32'(decimation_ratio), 32'd1);

      // reset mid-SETTLE
      request(3, 10, 20);
      step();
      for (int c = 0; c < 7; c++) step();
      #2 rst = 1'b1;
      model_reset();
      #1 check_all();
      chk("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      request(1, 4, 1);
      step();
      chk("post_rst_ready", 32'(req_ready), 32'b0010);
      chk("post_rst_dv", 32'(delay_valid), 32'd1);
      for (int c = 0; c < 12; c++) step();

      // identical to current config
      request(3, 4, 1);
      step();
      chk("same_ready", 32'(req_ready), 32'b1000);
      chk("same_dv", 32'(delay_valid), SKIP ? 32'd0 : 32'd1);
      chk("same_busy", 32'(busy), SKIP ? 32'd0 : 32'd1);
      for (int c = 0; c < 12; c++) step();

      // random traffic
      for (int c = 0; c < 2500; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!a_valid[i] && !cool[i] && $urandom_range(5) == 0) begin
               case ($urandom_range(7))
                  0: request(i, 0, int'($urandom_range(127)));
                  1: request(i, m_ratio, m_delay);
                  2: request(i, int'($urandom_range(1, 127)), int'($urandom_range(127)));
                  default: request(i, int'($urandom_range(1, 6)), int'($urandom_range(8)));
               endcase
            end else if (a_valid[i] && $urandom_range(39) == 0) a_valid[i] = 1'b0;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
